// File: rtl/rx_ipv4_filter.sv
// IPv4 receive parser: header capture, checksum, dst/proto filter,
// padding trim and payload forwarding for the Vthernet RX path.
module rx_ipv4_filter #(
  parameter int             OCT        = 8,
  parameter logic [OCT-1:0] PROTO_0    = 8'h11,
  parameter logic [OCT-1:0] PROTO_1    = 8'h01,
  parameter bit             CHECK_CSUM = 1'b1,
  parameter bit             CHECK_DST  = 1'b1
) (
  input  logic             RX_CLK,
  input  logic             rst_n,
  input  logic             func_en,
  input  logic [OCT*4-1:0] ip_addr,
  input  logic             rx_ethernet_data_v,
  input  logic [OCT-1:0]   rx_ethernet_data,
  input  logic             rx_ethernet_irq,
  output logic [OCT*4-1:0] rx_src_ip,
  output logic [OCT*4-1:0] rx_dst_ip,
  output logic [3:0]       rx_header_len,
  output logic [OCT*2-1:0] rx_total_len,
  output logic [OCT-1:0]   rx_ttl,
  output logic [OCT-1:0]   rx_protocol,
  output logic [OCT*2-1:0] rx_checksum,
  output logic             rx_ipv4_data_v,
  output logic [OCT-1:0]   rx_ipv4_data,
  output logic             rx_ipv4_last,
  output logic             rx_hdr_ok,
  output logic             rx_hdr_drop,
  output logic [2:0]       rx_drop_reason,
  output logic             rx_ipv4_trunc,
  output logic             rx_ipv4_irq
);

  localparam int W2 = OCT * 2;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DRAIN
  } state_t;

  state_t          state;
  logic [5:0]      hdr_cnt;
  logic [W2-1:0]   pay_cnt;
  logic [W2-1:0]   acc;
  logic [OCT-1:0]  prev_byte;
  logic [3:0]      ver_q;

  logic [W2:0]      sum_raw;
  logic [W2-1:0]    sum_fold;
  logic [OCT*4-1:0] dst_now;
  logic             hdr_last;
  logic             pay_last;
  logic [W2-1:0]    hdr_bytes;
  logic [2:0]       reason;
  logic [2:0]       early_reason;

  // Checksum step, end-of-header and end-of-payload detection
  always_comb begin
    sum_raw   = {1'b0, acc} + {1'b0, prev_byte, rx_ethernet_data};
    sum_fold  = sum_raw[W2-1:0] + W2'(sum_raw[W2]);
    hdr_last  = (hdr_cnt == {rx_header_len - 4'd1, 2'b11});
    pay_last  = (pay_cnt == rx_total_len - W2'(1));
    hdr_bytes = W2'({rx_header_len, 2'b00});
    dst_now   = rx_dst_ip;
    if (hdr_cnt == 6'd19)
      dst_now = {rx_dst_ip[OCT*3-1:0], rx_ethernet_data};
  end

  // Accept/reject code at the last header byte; lowest failing code wins
  always_comb begin
    reason = 3'd0;
    if (ver_q != 4'd4)
      reason = 3'd1;
    else if (rx_header_len < 4'd5)
      reason = 3'd2;
    else if (CHECK_CSUM && sum_fold != '1)
      reason = 3'd3;
    else if (CHECK_DST && dst_now != ip_addr && dst_now != '1)
      reason = 3'd4;
    else if (rx_protocol != PROTO_0 && rx_protocol != PROTO_1)
      reason = 3'd5;
    else if (rx_total_len <= hdr_bytes)
      reason = 3'd6;
  end

  // Version/IHL sanity on byte 0
  always_comb begin
    early_reason = 3'd0;
    if (rx_ethernet_data[7:4] != 4'd4)
      early_reason = 3'd1;
    else if (rx_ethernet_data[3:0] < 4'd5)
      early_reason = 3'd2;
  end

  // Parser state, field capture and registered outputs
  always_ff @(posedge RX_CLK) begin
    if (!rst_n) begin
      state          <= HDR;
      hdr_cnt        <= '0;
      pay_cnt        <= '0;
      acc            <= '0;
      prev_byte      <= '0;
      ver_q          <= '0;
      rx_src_ip      <= '0;
      rx_dst_ip      <= '0;
      rx_header_len  <= '0;
      rx_total_len   <= '0;
      rx_ttl         <= '0;
      rx_protocol    <= '0;
      rx_checksum    <= '0;
      rx_ipv4_data_v <= 1'b0;
      rx_ipv4_data   <= '0;
      rx_ipv4_last   <= 1'b0;
      rx_hdr_ok      <= 1'b0;
      rx_hdr_drop    <= 1'b0;
      rx_drop_reason <= '0;
      rx_ipv4_trunc  <= 1'b0;
      rx_ipv4_irq    <= 1'b0;
    end else begin
      rx_ipv4_data_v <= 1'b0;
      rx_ipv4_last   <= 1'b0;
      rx_hdr_ok      <= 1'b0;
      rx_hdr_drop    <= 1'b0;
      rx_ipv4_trunc  <= 1'b0;
      rx_ipv4_irq    <= 1'b0;
      if (func_en) begin
        rx_ipv4_irq <= rx_ethernet_irq;
        if (rx_ethernet_data_v) begin
          unique case (state)
            HDR: begin
              hdr_cnt   <= hdr_cnt + 6'd1;
              prev_byte <= rx_ethernet_data;
              if (hdr_cnt[0])
                acc <= sum_fold;
              case (hdr_cnt)
                6'd0: begin
                  ver_q         <= rx_ethernet_data[7:4];
                  rx_header_len <= rx_ethernet_data[3:0];
                end
                6'd2, 6'd3:
                  rx_total_len <= {rx_total_len[OCT-1:0], rx_ethernet_data};
                6'd8:
                  rx_ttl <= rx_ethernet_data;
                6'd9:
                  rx_protocol <= rx_ethernet_data;
                6'd10, 6'd11:
                  rx_checksum <= {rx_checksum[OCT-1:0], rx_ethernet_data};
                6'd12, 6'd13, 6'd14, 6'd15:
                  rx_src_ip <= {rx_src_ip[OCT*3-1:0], rx_ethernet_data};
                6'd16, 6'd17, 6'd18, 6'd19:
                  rx_dst_ip <= {rx_dst_ip[OCT*3-1:0], rx_ethernet_data};
                default: ;
              endcase
              if (hdr_cnt == 6'd0) begin
                if (early_reason != 3'd0) begin
                  rx_hdr_drop    <= 1'b1;
                  rx_drop_reason <= early_reason;
                  state          <= DRAIN;
                end
              end else if (hdr_last) begin
                if (reason != 3'd0) begin
                  rx_hdr_drop    <= 1'b1;
                  rx_drop_reason <= reason;
                  state          <= DRAIN;
                end else begin
                  rx_hdr_ok <= 1'b1;
                  pay_cnt   <= hdr_bytes;
                  state     <= PAYLOAD;
                end
              end
            end
            PAYLOAD: begin
              rx_ipv4_data_v <= 1'b1;
              rx_ipv4_data   <= rx_ethernet_data;
              pay_cnt        <= pay_cnt + W2'(1);
              if (pay_last) begin
                rx_ipv4_last <= 1'b1;
                state        <= DRAIN;
              end
            end
            DRAIN: ;
            default: state <= HDR;
          endcase
        end
        if (rx_ethernet_irq) begin
          state   <= HDR;
          hdr_cnt <= '0;
          pay_cnt <= '0;
          acc     <= '0;
          if (state == PAYLOAD && !(rx_ethernet_data_v && pay_last))
            rx_ipv4_trunc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_ipv4_filter.sv
// Directed bench for rx_ipv4_filter: frame sequences with
// hand-computed expectations checked by immediate assertions.
module tb_rx_ipv4_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        func_en;
  logic [31:0] ip_addr;
  logic        v;
  logic [7:0]  d;
  logic        irq;

  logic [31:0] src_ip, dst_ip;
  logic [3:0]  hlen;
  logic [15:0] tlen, csum;
  logic [7:0]  ttl, proto;
  logic        dv, last, ok, drop, trunc, irq_o;
  logic [7:0]  dat;
  logic [2:0]  rsn;

  logic [31:0] u_src, u_dst;
  logic [3:0]  u_hlen;
  logic [15:0] u_tlen, u_csum;
  logic [7:0]  u_ttl, u_proto, u_dat;
  logic        u_dv, u_last, u_ok, u_drop, u_trunc, u_irq;
  logic [2:0]  u_rsn;

  int vecs = 0;
  int miss = 0;

  logic [7:0] fr[$];
  logic [7:0] rxq[$];
  int n_ok, n_drop, n_last, n_trunc, n_ok2, last_idx, win_hits;
  bit ok_first, in_win;
  logic irq_seen, irq_after;

  always #5 clk = ~clk;

  rx_ipv4_filter dut (
    .RX_CLK(clk), .rst_n(rst_n), .func_en(func_en),
    .ip_addr(ip_addr), .rx_ethernet_data_v(v),
    .rx_ethernet_data(d), .rx_ethernet_irq(irq),
    .rx_src_ip(src_ip), .rx_dst_ip(dst_ip),
    .rx_header_len(hlen), .rx_total_len(tlen),
    .rx_ttl(ttl), .rx_protocol(proto), .rx_checksum(csum),
    .rx_ipv4_data_v(dv), .rx_ipv4_data(dat),
    .rx_ipv4_last(last), .rx_hdr_ok(ok), .rx_hdr_drop(drop),
    .rx_drop_reason(rsn), .rx_ipv4_trunc(trunc),
    .rx_ipv4_irq(irq_o)
  );

  rx_ipv4_filter #(.CHECK_CSUM(1'b0)) dut_nocs (
    .RX_CLK(clk), .rst_n(rst_n), .func_en(func_en),
    .ip_addr(ip_addr), .rx_ethernet_data_v(v),
    .rx_ethernet_data(d), .rx_ethernet_irq(irq),
    .rx_src_ip(u_src), .rx_dst_ip(u_dst),
    .rx_header_len(u_hlen), .rx_total_len(u_tlen),
    .rx_ttl(u_ttl), .rx_protocol(u_proto), .rx_checksum(u_csum),
    .rx_ipv4_data_v(u_dv), .rx_ipv4_data(u_dat),
    .rx_ipv4_last(u_last), .rx_hdr_ok(u_ok), .rx_hdr_drop(u_drop),
    .rx_drop_reason(u_rsn), .rx_ipv4_trunc(u_trunc),
    .rx_ipv4_irq(u_irq)
  );

  // Output monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (dv === 1'b1) begin
      rxq.push_back(dat);
      if (last === 1'b1) last_idx = rxq.size();
    end
    if (last === 1'b1) n_last++;
    if (ok === 1'b1) begin
      n_ok++;
      if (rxq.size() == 0) ok_first = 1'b1;
    end
    if (drop === 1'b1) n_drop++;
    if (trunc === 1'b1) n_trunc++;
    if (u_ok === 1'b1) n_ok2++;
    if (in_win && (dv | last | ok | drop | trunc | irq_o) !== 1'b0)
      win_hits++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rxq.delete();
    n_ok = 0; n_drop = 0; n_last = 0; n_trunc = 0; n_ok2 = 0;
    last_idx = 0; win_hits = 0; ok_first = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    v = 1'b1; d = b;
    @(posedge clk); #1;
    v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_irq();
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
    irq_seen = irq_o;
    @(posedge clk); #1;
    irq_after = irq_o;
  endtask

  // Frame image: header (checksum filled in), payload A0.., pad 55
  task automatic build(input logic [7:0] b0, input int ihl,
                       input int tl, input logic [7:0] pr,
                       input logic [31:0] dst, input int npay,
                       input int npad, input bit bad);
    logic [7:0]  h[60];
    logic [31:0] s;
    logic [15:0] c;
    int nh;
    nh = ihl * 4;
    for (int i = 0; i < 60; i++) h[i] = 8'h01 + 8'(i);
    h[0] = b0;     h[1] = 8'h00;
    h[2] = tl[15:8]; h[3] = tl[7:0];
    h[4] = 8'h12;  h[5] = 8'h34;
    h[6] = 8'h40;  h[7] = 8'h00;
    h[8] = 8'h40;  h[9] = pr;
    h[10] = 8'h00; h[11] = 8'h00;
    h[12] = 8'h0A; h[13] = 8'h00; h[14] = 8'h00; h[15] = 8'h02;
    h[16] = dst[31:24]; h[17] = dst[23:16];
    h[18] = dst[15:8];  h[19] = dst[7:0];
    s = 0;
    for (int i = 0; i < nh / 2; i++) s = s + {16'h0, h[2*i], h[2*i+1]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    c = ~s[15:0];
    h[10] = c[15:8];
    h[11] = c[7:0] + 8'(bad);
    fr.delete();
    for (int i = 0; i < nh; i++) fr.push_back(h[i]);
    for (int i = 0; i < npay; i++) fr.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < npad; i++) fr.push_back(8'h55);
  endtask

  task automatic run_frame();
    clr();
    foreach (fr[i]) push(fr[i]);
    pulse_irq();
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0; func_en = 1'b1; ip_addr = 32'h0A000001;
    v = 1'b0; d = 8'h00; irq = 1'b0; in_win = 1'b0;
    clr();
    idle(3);
    chk("rst_dv", 32'(dv), 0);
    chk("rst_ok", 32'(ok), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_reason", 32'(rsn), 0);
    chk("rst_irq", 32'(irq_o), 0);
    rst_n = 1'b1;
    idle(2);

    // Valid UDP frame
    build(8'h45, 5, 28, 8'h11, 32'h0A000001, 8, 18, 1'b0);
    run_frame();
    chk("udp_ok", 32'(n_ok), 1);
    chk("udp_drop", 32'(n_drop), 0);
    chk("udp_nbytes", 32'(rxq.size()), 8);
    chk("udp_first", 32'(rxq[0]), 32'hA0);
    chk("udp_8th", 32'(rxq[7]), 32'hA7);
    chk("udp_nlast", 32'(n_last), 1);
    chk("udp_lastidx", 32'(last_idx), 8);
    chk("udp_ok_first", 32'(ok_first), 1);
    chk("udp_trunc", 32'(n_trunc), 0);
    chk("udp_irq_dly", 32'(irq_seen), 1);
    chk("udp_irq_end", 32'(irq_after), 0);
    chk("udp_tlen", 32'(tlen), 28);
    chk("udp_ttl", 32'(ttl), 32'h40);
    chk("udp_proto", 32'(proto), 32'h11);

    // IHL=6 with options
    build(8'h46, 6, 30, 8'h11, 32'h0A000001, 6, 16, 1'b0);
    run_frame();
    chk("opt_ok", 32'(n_ok), 1);
    chk("opt_nbytes", 32'(rxq.size()), 6);
    chk("opt_first", 32'(rxq[0]), 32'hA0);
    chk("opt_lastidx", 32'(last_idx), 6);
    chk("opt_src", src_ip, 32'h0A000002);
    chk("opt_dst", dst_ip, 32'h0A000001);
    chk("opt_hlen", 32'(hlen), 6);

    // Checksum corrupted by +1
    build(8'h45, 5, 28, 8'h11, 32'h0A000001, 8, 18, 1'b1);
    run_frame();
    chk("cs_drop", 32'(n_drop), 1);
    chk("cs_reason", 32'(rsn), 3);
    chk("cs_nbytes", 32'(rxq.size()), 0);
    chk("cs_nocheck_ok", 32'(n_ok2), 1);

    // Destination not ours
    build(8'h45, 5, 28, 8'h11, 32'h0A000063, 8, 18, 1'b0);
    run_frame();
    chk("dst_drop", 32'(n_drop), 1);
    chk("dst_reason", 32'(rsn), 4);

    // Broadcast destination
    build(8'h45, 5, 28, 8'h11, 32'hFFFFFFFF, 8, 18, 1'b0);
    run_frame();
    chk("bc_ok", 32'(n_ok), 1);
    chk("bc_nbytes", 32'(rxq.size()), 8);

    // Unsupported protocol
    build(8'h45, 5, 28, 8'h06, 32'h0A000001, 8, 18, 1'b0);
    run_frame();
    chk("pr_drop", 32'(n_drop), 1);
    chk("pr_reason", 32'(rsn), 5);
    chk("pr_nbytes", 32'(rxq.size()), 0);

    // IHL=4 rejected on byte 0
    build(8'h44, 5, 28, 8'h11, 32'h0A000001, 8, 18, 1'b0);
    clr();
    push(fr[0]);
    chk("ihl_drop_now", 32'(drop), 1);
    chk("ihl_reason", 32'(rsn), 2);
    for (int i = 1; i < fr.size(); i++) push(fr[i]);
    pulse_irq();
    idle(3);
    chk("ihl_ndrop", 32'(n_drop), 1);
    chk("ihl_nbytes", 32'(rxq.size()), 0);

    // Total Length equal to header length
    build(8'h45, 5, 20, 8'h11, 32'h0A000001, 0, 26, 1'b0);
    run_frame();
    chk("tl_drop", 32'(n_drop), 1);
    chk("tl_reason", 32'(rsn), 6);

    // Truncated frame, then a good one
    build(8'h45, 5, 100, 8'h11, 32'h0A000001, 10, 0, 1'b0);
    run_frame();
    chk("tr_nbytes", 32'(rxq.size()), 10);
    chk("tr_nlast", 32'(n_last), 0);
    chk("tr_trunc", 32'(n_trunc), 1);
    build(8'h45, 5, 28, 8'h11, 32'h0A000001, 8, 18, 1'b0);
    run_frame();
    chk("tr_next_ok", 32'(n_ok), 1);
    chk("tr_next_n", 32'(rxq.size()), 8);
    chk("tr_next_trunc", 32'(n_trunc), 0);

    // func_en low mid-payload with data_v activity
    clr();
    for (int i = 0; i < 23; i++) push(fr[i]);
    func_en = 1'b0;
    v = 1'b1; d = 8'hEE;
    @(posedge clk); #1;
    in_win = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v = k[0]; d = 8'hE0 + 8'(k);
      @(posedge clk); #1;
    end
    func_en = 1'b1; v = 1'b0; in_win = 1'b0;
    for (int i = 23; i < fr.size(); i++) push(fr[i]);
    pulse_irq();
    idle(3);
    chk("en_window", 32'(win_hits), 0);
    chk("en_nbytes", 32'(rxq.size()), 8);
    chk("en_4th", 32'(rxq[3]), 32'hA3);
    chk("en_8th", 32'(rxq[7]), 32'hA7);
    chk("en_lastidx", 32'(last_idx), 8);

    // Reset mid-header, then a good frame
    clr();
    for (int i = 0; i < 10; i++) push(fr[i]);
    rst_n = 1'b0;
    idle(2);
    chk("mr_reason", 32'(rsn), 0);
    chk("mr_tlen", 32'(tlen), 0);
    chk("mr_src", src_ip, 0);
    chk("mr_data", 32'(dat), 0);
    rst_n = 1'b1;
    idle(1);
    run_frame();
    chk("mr_next_ok", 32'(n_ok), 1);
    chk("mr_next_n", 32'(rxq.size()), 8);
    chk("mr_next_last", 32'(last_idx), 8);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
